// File: rtl/interleaver_block_ctrl.sv
// Sequencing controller for the interleaver datapath: loads K/8 bytes into the
// input shift register, then walks the bit-select index 0..K-1 under backpressure.
module interleaver_block_ctrl (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        k_sel_in,
  input  logic        abort,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        shift_en,
  output logic        k_size_6144,
  output logic [13:0] mux_ind,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    STREAM,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  byte_cnt;
  logic [9:0]  byte_cnt_nxt;
  logic [9:0]  byte_cnt_inc;
  logic [13:0] mux_ind_nxt;
  logic        k_size_nxt;
  logic [9:0]  byte_target;
  logic [13:0] last_ind;

  assign byte_target  = k_size_6144 ? 10'd768 : 10'd132;
  assign last_ind     = k_size_6144 ? 14'd6143 : 14'd1055;
  assign byte_cnt_inc = byte_cnt + 10'd1;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      mux_ind     <= '0;
      k_size_6144 <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      mux_ind     <= mux_ind_nxt;
      k_size_6144 <= k_size_nxt;
    end
  end

  // Handshake outputs are decoded from the current state so reset clears them immediately.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    mux_ind_nxt  = mux_ind;
    k_size_nxt   = k_size_6144;
    byte_ready   = 1'b0;
    shift_en     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          k_size_nxt   = k_sel_in;
          byte_cnt_nxt = '0;
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        shift_en   = byte_valid;
        if (byte_valid) begin
          byte_cnt_nxt = byte_cnt_inc;
          if (byte_cnt_inc == byte_target) begin
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        mux_ind_nxt = '0;
        state_nxt   = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = (mux_ind == last_ind);
        if (out_ready) begin
          if (mux_ind == last_ind) begin
            state_nxt = DONE;
          end else begin
            mux_ind_nxt = mux_ind + 14'd1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides every transition except from IDLE, where it only blocks start.
    if (abort && (state != IDLE)) begin
      state_nxt    = IDLE;
      byte_cnt_nxt = '0;
      mux_ind_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_interleaver_block_ctrl.sv
// Scoreboard bench for interleaver_block_ctrl: stimulus queues expected transfers
// and done records; a negedge monitor pops and compares them.
module tb_interleaver_block_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        k_sel_in = 1'b0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        byte_ready;
  logic        shift_en;
  logic        k_size_6144;
  logic [13:0] mux_ind;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        done;

  interleaver_block_ctrl dut (
    .clock       (clock),
    .rst         (rst),
    .start       (start),
    .k_sel_in    (k_sel_in),
    .abort       (abort),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .shift_en    (shift_en),
    .k_size_6144 (k_size_6144),
    .mux_ind     (mux_ind),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int idx;
    int last;
  } xfer_t;

  xfer_t exp_q[$];
  int    lat_q[$];
  int    bytes_q[$];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    shift_count = 0;
  int    mode = 0;
  xfer_t mon_e;
  int    mon_lat;
  int    mon_bytes;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Mode 0: no stalls; mode 1: byte_valid toggles, out_ready low every third cycle.
  always @(posedge clock) begin
    #2;
    case (mode)
      0: begin
        byte_valid = 1'b1;
        out_ready  = 1'b1;
      end
      1: begin
        byte_valid = cyc[0];
        out_ready  = ((cyc % 3) != 0);
      end
      default: begin
        byte_valid = 1'b0;
        out_ready  = 1'b0;
      end
    endcase
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!busy) shift_count = 0;
    else if (shift_en) shift_count++;

    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_xfer", int'(mux_ind), -1);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("mux_ind", int'(mux_ind), mon_e.idx);
        check_output("out_last", int'(out_last), mon_e.last);
      end
    end

    if (out_last && !out_valid) check_output("out_last_without_valid", 1, 0);

    if (done) begin
      if (lat_q.size() == 0) begin
        check_output("unexpected_done", 1, 0);
      end else begin
        mon_lat   = lat_q.pop_front();
        mon_bytes = bytes_q.pop_front();
        if (mon_lat >= 0) check_output("latency", cyc - start_cyc, mon_lat);
        check_output("shift_count", shift_count, mon_bytes);
        check_output("xfers_left_at_done", exp_q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_xfers(input int count, input int k);
    xfer_t x;
    for (int i = 0; i < count; i++) begin
      x.idx  = i;
      x.last = (i == k - 1) ? 1 : 0;
      exp_q.push_back(x);
    end
  endtask

  task automatic push_block(input bit k6144, input int lat);
    int k;
    k = k6144 ? 6144 : 1056;
    push_xfers(k, k);
    lat_q.push_back(lat);
    bytes_q.push_back(k6144 ? 768 : 132);
  endtask

  task automatic apply_stimulus(input bit k6144);
    k_sel_in  = k6144;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check_output("busy_after_start", int'(busy), 1);
    check_output("byte_ready_after_start", int'(byte_ready), 1);
    check_output("k_size_latched", int'(k_size_6144), int'(k6144));
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check_output("done_within_budget", int'(done), 1);
    tick();
    check_output("idle_after_done", int'(busy), 0);
  endtask

  task automatic wait_index(input int idx, input int limit);
    int n;
    n = 0;
    while (!(out_valid && int'(mux_ind) == idx) && n < limit) begin
      tick();
      n++;
    end
    check_output("reached_index", int'(mux_ind), idx);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mode = 0;
    repeat (3) tick();
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_byte_ready", int'(byte_ready), 0);
    check_output("rst_shift_en", int'(shift_en), 0);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_k_size", int'(k_size_6144), 0);
    check_output("rst_mux_ind", int'(mux_ind), 0);
    rst = 1'b1;
    tick();

    $display("[TB] full 1056 block, no stalls");
    push_block(1'b0, 1190);
    apply_stimulus(1'b0);
    wait_done(2000);

    $display("[TB] full 6144 block with gaps");
    mode = 1;
    push_block(1'b1, -1);
    apply_stimulus(1'b1);
    wait_done(20000);
    mode = 0;
    check_output("k_size_held_in_idle", int'(k_size_6144), 1);

    $display("[TB] start and abort together in IDLE");
    k_sel_in = 1'b0;
    start    = 1'b1;
    abort    = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_busy", int'(busy), 0);
    check_output("start_abort_byte_ready", int'(byte_ready), 0);
    check_output("start_abort_k_size", int'(k_size_6144), 1);
    tick();
    check_output("start_abort_busy_later", int'(busy), 0);

    $display("[TB] ignored start during LOAD and STREAM");
    push_block(1'b0, 1190);
    apply_stimulus(1'b0);
    repeat (20) tick();
    k_sel_in = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    k_sel_in = 1'b0;
    check_output("ignored_start_load_k", int'(k_size_6144), 0);
    check_output("ignored_start_load_ready", int'(byte_ready), 1);
    wait_index(10, 400);
    k_sel_in = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    k_sel_in = 1'b0;
    check_output("ignored_start_stream_k", int'(k_size_6144), 0);
    check_output("ignored_start_stream_valid", int'(out_valid), 1);
    wait_done(2000);
    repeat (3) tick();
    check_output("no_new_block", int'(busy), 0);

    $display("[TB] abort during LOAD");
    apply_stimulus(1'b0);
    repeat (49) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_load_busy", int'(busy), 0);
    check_output("abort_load_byte_ready", int'(byte_ready), 0);
    check_output("abort_load_shift_en", int'(shift_en), 0);
    check_output("abort_load_done", int'(done), 0);
    repeat (2) tick();

    $display("[TB] abort during STREAM");
    push_xfers(301, 1056);
    apply_stimulus(1'b0);
    wait_index(300, 2000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_stream_busy", int'(busy), 0);
    check_output("abort_stream_mux_ind", int'(mux_ind), 0);
    check_output("abort_stream_out_valid", int'(out_valid), 0);
    check_output("abort_stream_done", int'(done), 0);
    check_output("abort_stream_queue", exp_q.size(), 0);
    repeat (2) tick();
    push_block(1'b0, 1190);
    apply_stimulus(1'b0);
    wait_done(2000);

    $display("[TB] reset mid-STREAM");
    push_xfers(500, 6144);
    apply_stimulus(1'b1);
    wait_index(500, 8000);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_rst_busy", int'(busy), 0);
    check_output("async_rst_out_valid", int'(out_valid), 0);
    check_output("async_rst_mux_ind", int'(mux_ind), 0);
    check_output("async_rst_k_size", int'(k_size_6144), 0);
    check_output("async_rst_byte_ready", int'(byte_ready), 0);
    check_output("async_rst_queue", exp_q.size(), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_output("post_rst_k_size", int'(k_size_6144), 0);
    push_block(1'b0, 1190);
    apply_stimulus(1'b0);
    wait_done(2000);

    repeat (5) tick();
    check_output("final_xfer_queue", exp_q.size(), 0);
    check_output("final_done_queue", lat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
